gp_prefetch_fifo: RTL and testbench

//  Parametrised DRAM prefetch FIFO feeding the graphics processor (GP) command stream.

---
 rtl/gp_pkg.sv | 25 ++
 rtl/gp_line_unpack.sv | 40 ++++
 rtl/gp_prefetch_fifo.sv | 170 +++++++++++++++++
 tb/tb_gp_prefetch_fifo.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gp_pkg.sv
// Shared types, default widths and a constant clog2 helper for the GP prefetch FIFO.
// Optional stall statistics in the top are enabled by GP_PREFETCH_STATS_EN.
package gp_pkg;

   localparam int GP_DATA_W = 32;
   localparam int GP_MEM_W  = 128;
   localparam int GP_ADDR_W = 31;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } gp_state_e;

   // Smallest r with 2**r >= value; usable in constant expressions.
   function automatic int gp_clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/gp_line_unpack.sv
// Selects successive DATA_W words out of one MEM_W line, word 0 from the low bits.
// Keeps the sub-word counter and flags the last word of the line.
module gp_line_unpack
   import gp_pkg::*;
#(
   parameter int DATA_W = GP_DATA_W,
   parameter int MEM_W  = GP_MEM_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              adv_i,
   input  logic [MEM_W-1:0]  line_i,
   output logic [DATA_W-1:0] word_o,
   output logic              last_o
);

   localparam int WPL = MEM_W / DATA_W;
   localparam int SW  = (WPL > 1) ? gp_clog2(WPL) : 1;

   logic [SW-1:0] sub_q, sub_d;

   assign word_o = line_i[int'(sub_q) * DATA_W +: DATA_W];
   assign last_o = (sub_q == SW'(WPL - 1));

   always_comb begin
      sub_d = sub_q;
      if (clr_i) begin
         sub_d = '0;
      end else if (adv_i) begin
         sub_d = last_o ? '0 : sub_q + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sub_q <= '0;
      else        sub_q <= sub_d;
   end

endmodule

// File: rtl/gp_prefetch_fifo.sv
// DRAM prefetch FIFO for the GP command stream: credit-limited burst requests, line storage,
// word unpacking and abort/drain. Define GP_PREFETCH_STATS_EN to add the stall_cnt output.
module gp_prefetch_fifo
   import gp_pkg::*;
#(
   parameter int DATA_W      = GP_DATA_W,
   parameter int MEM_W       = GP_MEM_W,
   parameter int ADDR_W      = GP_ADDR_W,
   parameter int DEPTH_LINES = 8,
   parameter int BURST_BEATS = 2,
   parameter int ADDR_INC    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              abort,
   output logic              busy,
   output logic              af_wr_en,
   output logic [ADDR_W-1:0] af_addr_din,
   input  logic              af_full,
   input  logic              rdf_valid,
   input  logic [MEM_W-1:0]  rdf_dout,
   output logic              rdf_rd_en,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
`ifdef GP_PREFETCH_STATS_EN
   output logic [31:0]       stall_cnt,
`endif
   output gp_state_e         dbg_state
);

   localparam int LW = gp_clog2(DEPTH_LINES);
   localparam int PW = LW + 1;
   localparam int CW = PW + 2;
   localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(ADDR_INC - 1);

   gp_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [PW-1:0]     outst_q, outst_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [MEM_W-1:0]  mem_q [DEPTH_LINES];

   logic              start_acc, flush, fire, beat_in, wr_en, credit_ok;
   logic              line_avail, can_load, last_word;
   logic [PW-1:0]     count, free_lines;
   logic [MEM_W-1:0]  line_src;
   logic [DATA_W-1:0] word;

   assign start_acc  = (state_q == ST_IDLE) && start && !abort;
   assign flush      = abort && (state_q != ST_IDLE);
   assign count      = wr_ptr_q - rd_ptr_q;
   assign free_lines = PW'(DEPTH_LINES) - count;
   // Space already promised to in-flight beats is not available for new requests.
   assign credit_ok  = (CW'(free_lines) >= CW'(outst_q) + CW'(BURST_BEATS));
   assign af_wr_en   = (state_q == ST_FETCH) && credit_ok;
   assign fire       = af_wr_en && !af_full;
   assign beat_in    = rdf_valid && (state_q != ST_IDLE);
   assign wr_en      = rdf_valid && (state_q == ST_FETCH) && !flush;

   // Output handshake: a word moves when out_valid & out_ready; out_valid/out_data only
   // change when the register is empty or its word is being taken this cycle.
   assign line_avail = (count != '0);
   assign line_src   = line_avail ? mem_q[rd_ptr_q[LW-1:0]] : rdf_dout;
   assign can_load   = (state_q == ST_FETCH) && !flush && (line_avail || wr_en)
                       && (!out_valid_q || out_ready);

   gp_line_unpack #(
      .DATA_W (DATA_W),
      .MEM_W  (MEM_W)
   ) u_unpack (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (flush),
      .adv_i  (can_load),
      .line_i (line_src),
      .word_o (word),
      .last_o (last_word)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (start_acc) begin
               state_d = ST_FETCH;
               addr_d  = start_addr & ADDR_MASK;
            end
         end
         ST_FETCH: if (abort) state_d = ST_DRAIN;
         ST_DRAIN: if (outst_d == '0) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (fire) addr_d = addr_q + ADDR_W'(ADDR_INC);
   end

   always_comb begin
      outst_d     = outst_q + (fire ? PW'(BURST_BEATS) : '0) - (beat_in ? PW'(1) : '0);
      wr_ptr_d    = wr_ptr_q + (wr_en ? PW'(1) : '0);
      rd_ptr_d    = rd_ptr_q + ((can_load && last_word) ? PW'(1) : '0);
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (out_ready) out_valid_d = 1'b0;
      if (can_load) begin
         out_valid_d = 1'b1;
         out_data_d  = word;
      end
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         outst_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         outst_q     <= outst_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[LW-1:0]] <= rdf_dout;
   end

`ifdef GP_PREFETCH_STATS_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (start_acc) begin
         stall_d = '0;
      end else if (busy && out_ready && !out_valid_q && (stall_q != '1)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif

   assign busy        = (state_q != ST_IDLE);
   assign af_addr_din = addr_q;
   assign rdf_rd_en   = 1'b1;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_gp_prefetch_fifo.sv
// Bench for gp_prefetch_fifo: DRAM responder model, expected-word queue checked by a
// monitor, and directed scenarios for credit, back-pressure, abort and reset.
`timescale 1ns/1ps
module tb_gp_prefetch_fifo;
   import gp_pkg::*;

   localparam int DATA_W      = 32;
   localparam int MEM_W       = 128;
   localparam int ADDR_W      = 31;
   localparam int DEPTH_LINES = 8;
   localparam int BURST_BEATS = 2;
   localparam int ADDR_INC    = 8;
   localparam int WPL         = MEM_W / DATA_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] start_addr = '0;
   logic              abort = 1'b0;
   logic              busy, af_wr_en, rdf_rd_en, out_valid;
   logic [ADDR_W-1:0] af_addr_din;
   logic              af_full = 1'b0;
   logic              rdf_valid = 1'b0;
   logic [MEM_W-1:0]  rdf_dout = '0;
   logic [DATA_W-1:0] out_data;
   logic              out_ready = 1'b0;
   gp_state_e         dbg_state;
`ifdef GP_PREFETCH_STATS_EN
   logic [31:0]       stall_cnt;
`endif

   typedef struct {
      int                due;
      logic [ADDR_W-1:0] addr;
      int                beat;
   } pend_t;

   int                checks = 0;
   int                failures = 0;
   int                cyc = 0;
   int                lat = 3;
   bit                discard = 1'b1;
   int                fire_cnt = 0;
   int                fire_cyc_q[$];
   int                last_beat_cyc = 0;
   int                start_cyc = 0;
   logic [ADDR_W-1:0] exp_addr = '0;
   pend_t             pend_q[$];
   logic [DATA_W-1:0] exp_q[$];

   gp_prefetch_fifo #(
      .DATA_W      (DATA_W),
      .MEM_W       (MEM_W),
      .ADDR_W      (ADDR_W),
      .DEPTH_LINES (DEPTH_LINES),
      .BURST_BEATS (BURST_BEATS),
      .ADDR_INC    (ADDR_INC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .start_addr  (start_addr),
      .abort       (abort),
      .busy        (busy),
      .af_wr_en    (af_wr_en),
      .af_addr_din (af_addr_din),
      .af_full     (af_full),
      .rdf_valid   (rdf_valid),
      .rdf_dout    (rdf_dout),
      .rdf_rd_en   (rdf_rd_en),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
`ifdef GP_PREFETCH_STATS_EN
      .stall_cnt   (stall_cnt),
`endif
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] beat_word(input logic [ADDR_W-1:0] a, input int b,
                                                   input int i);
      return DATA_W'(a) * DATA_W'(16) + DATA_W'(b * WPL + i);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_start(input logic [ADDR_W-1:0] a);
      start      = 1'b1;
      start_addr = a;
      exp_addr   = a & ~ADDR_W'(ADDR_INC - 1);
      discard    = 1'b0;
      fire_cnt   = 0;
      fire_cyc_q.delete();
      start_cyc  = cyc;
      tick(1);
      start      = 1'b0;
   endtask

   task automatic do_abort();
      abort   = 1'b1;
      discard = 1'b1;
      tick(1);
      abort   = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_ov(input int budget, output int at_cyc);
      int n;
      n = 0;
      while (!out_valid && n < budget) begin
         tick(1);
         n++;
      end
      checks++;
      if (!out_valid) begin
         failures++;
         $display("FAIL wait_out_valid: out_valid still 0 after %0d cycles, expected 1", budget);
      end
      at_cyc = cyc;
   endtask

   task automatic wait_busy_low(input int budget, output int at_cyc);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick(1);
         n++;
      end
      checks++;
      if (busy) begin
         failures++;
         $display("FAIL busy_fall: busy still 1 after %0d cycles, expected 0", budget);
      end
      at_cyc = cyc;
   endtask

   // ---------------- DRAM responder ----------------
   always @(posedge clk) begin : dram_drv
      pend_t             p;
      logic [DATA_W-1:0] w;
      cyc++;
      #1;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
         p = pend_q.pop_front();
         rdf_valid = 1'b1;
         for (int i = 0; i < WPL; i++) begin
            w = beat_word(p.addr, p.beat, i);
            rdf_dout[i*DATA_W +: DATA_W] = w;
            if (!discard) exp_q.push_back(w);
         end
         last_beat_cyc = cyc;
      end else begin
         rdf_valid = 1'b0;
      end
   end

   // ---------------- request sampler and scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_n && af_wr_en && !af_full) begin
         check("req_addr", 64'(af_addr_din), 64'(exp_addr));
         fire_cnt++;
         fire_cyc_q.push_back(cyc);
         for (int b = 0; b < BURST_BEATS; b++)
            pend_q.push_back('{due: cyc + lat, addr: af_addr_din, beat: b});
         exp_addr = exp_addr + ADDR_W'(ADDR_INC);
      end
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_word: got 0x%0h expected no word (queue empty)", out_data);
         end else begin
            check("out_word", 64'(out_data), 64'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int c0, c1, n;

      // reset state
      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_af_wr_en", 64'(af_wr_en), 64'd0);
      check("rst_af_addr", 64'(af_addr_din), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // 1: back-to-back requests, in-order words at one per cycle
      lat = 3;
      out_ready = 1'b1;
      do_start(ADDR_W'(32'h100));
      wait_ov(20, c0);
      check("t1_first_word_cycle", 64'(c0), 64'(start_cyc + 2 + lat));
      check("t1_four_req_b2b", 64'(fire_cyc_q[3] - fire_cyc_q[0]), 64'd3);
      n = 0;
      for (int i = 0; i < 32; i++) begin
         if (out_valid) n++;
         tick(1);
      end
      check("t1_throughput", 64'(n), 64'd32);
      do_abort();
      check("t1_abort_out_valid", 64'(out_valid), 64'd0);
      check("t1_abort_af_wr_en", 64'(af_wr_en), 64'd0);
      wait_busy_low(60, c1);

      // 2: consumer stalled, credit limit, then one transfer frees no burst
      out_ready = 1'b0;
      do_start(ADDR_W'(32'h20F));
      tick(30);
      check("t2_req_count", 64'(fire_cnt), 64'(DEPTH_LINES / BURST_BEATS));
      check("t2_af_wr_en_low", 64'(af_wr_en), 64'd0);
      check("t2_word_waiting", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      tick(10);
      check("t2_no_req_after_one", 64'(fire_cnt), 64'(DEPTH_LINES / BURST_BEATS));
      out_ready = 1'b1;
      tick(30);
      check("t2_req_resumes", 64'(fire_cnt > DEPTH_LINES / BURST_BEATS), 64'd1);
      do_abort();
      wait_busy_low(60, c1);

      // 3: request held under af_full
      lat = 3;
      out_ready = 1'b1;
      do_start(ADDR_W'(32'h100));
      tick(1);
      af_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_wr_en", 64'(af_wr_en), 64'd1);
         check("t3_hold_addr", 64'(af_addr_din), 64'h108);
         tick(1);
      end
      check("t3_req_before_release", 64'(fire_cnt), 64'd1);
      af_full = 1'b0;
      tick(40);
      check("t3_req_after_release", 64'(fire_cnt > 1), 64'd1);
      do_abort();
      wait_busy_low(60, c1);

      // 4: abort with four beats outstanding and a withdrawn held request
      lat = 10;
      out_ready = 1'b1;
      do_start(ADDR_W'(32'h300));
      tick(2);
      af_full = 1'b1;
      check("t4_req_count", 64'(fire_cnt), 64'd2);
      tick(1);
      do_abort();
      af_full = 1'b0;
      check("t4_drain_wr_en", 64'(af_wr_en), 64'd0);
      check("t4_drain_busy", 64'(busy), 64'd1);
      check("t4_drain_state", 64'(dbg_state), 64'(ST_DRAIN));
      start = 1'b1;
      start_addr = ADDR_W'(32'h700);
      tick(1);
      start = 1'b0;
      wait_busy_low(40, c1);
      check("t4_busy_after_last_beat", 64'(c1), 64'(last_beat_cyc + 1));
      tick(5);
      check("t4_start_ignored_req", 64'(fire_cnt), 64'd2);
      check("t4_start_ignored_busy", 64'(busy), 64'd0);

      // 5: reset mid-burst, stray beats afterwards
      lat = 3;
      out_ready = 1'b1;
      do_start(ADDR_W'(32'h400));
      tick(8);
      check("t5_running", 64'(out_valid), 64'd1);
      #1;
      rst_n = 1'b0;
      discard = 1'b1;
      #1;
      exp_q.delete();
      check("t5_rst_busy", 64'(busy), 64'd0);
      check("t5_rst_af_wr_en", 64'(af_wr_en), 64'd0);
      check("t5_rst_af_addr", 64'(af_addr_din), 64'd0);
      check("t5_rst_out_valid", 64'(out_valid), 64'd0);
      check("t5_rst_out_data", 64'(out_data), 64'd0);
      tick(2);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         if (out_valid) n++;
         tick(1);
      end
      check("t5_stray_no_valid", 64'(n), 64'd0);
      check("t5_idle_busy", 64'(busy), 64'd0);

`ifdef GP_PREFETCH_STATS_EN
      // 6: stall counter with DRAM latency 10
      lat = 10;
      out_ready = 1'b1;
      do_start(ADDR_W'(32'h500));
      wait_ov(30, c0);
      check("t6_stall_cnt", 64'(stall_cnt), 64'd11);
      do_abort();
      wait_busy_low(60, c1);
`endif

      tick(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
